// File: rtl/counter_bcd_hex.sv
// counter_bcd_hex: up/down modulo counter with double-dabble BCD and 7-seg drive.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module counter_bcd_hex #(
  parameter int N        = 8,
  parameter int MOD      = 200,
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 12_500_000
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                up_dn,
  input  logic                load,
  input  logic [N-1:0]        load_val,
  output logic [N-1:0]        count,
  output logic                wrap,
  output logic                busy,
  output logic [7*DIGITS-1:0] hex
);
  localparam int NW = N + 1;
  localparam int PW = $clog2(PRESCALE);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + N;
  localparam int IW = $clog2(N + 1);
  localparam logic [N:0] MOD_W = NW'(MOD);
  localparam logic [N:0] MODM1 = NW'(MOD - 1);
  localparam longint P10 = longint'(10) ** DIGITS;
  localparam logic [7*DIGITS-1:0] HEX_ZERO = {DIGITS{7'b1000000}};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7*DIGITS-1:0] HEX_RST =
    ({(7*DIGITS){1'b1}} << 7) | (7*DIGITS)'(7'b1000000);
`else
  localparam logic [7*DIGITS-1:0] HEX_RST = HEX_ZERO;
`endif

  if (MOD < 2 || longint'(MOD) > (longint'(1) << N) ||
      longint'(MOD - 1) > P10 - 1 || PRESCALE < N + 3) begin : g_bad_cfg
    $error("counter_bcd_hex: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  logic [PW-1:0]       pcnt_q;
  logic                tick;
  logic [N-1:0]        cnt_q, cnt_d;
  logic                wrap_q, wrap_d;
  logic                req_q, req_d;
  logic [N:0]          cw, nxt;
  state_t              state_q;
  logic                pending_q;
  logic [IW-1:0]       i_q;
  logic [SW-1:0]       sh_q;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic [3:0]          dig;
`ifdef LEADING_ZERO_BLANK_EN
  logic                nz;
`endif

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int k = 0; k < DIGITS; k++)
      if (t[N+4*k +: 4] >= 4'd5)
        t[N+4*k +: 4] = t[N+4*k +: 4] + 4'd3;
    return {t[SW-2:0], 1'b0};
  endfunction

  assign tick = (pcnt_q == PW'(PRESCALE - 1));

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n)  pcnt_q <= '0;
    else if (tick) pcnt_q <= '0;
    else           pcnt_q <= pcnt_q + PW'(1);
  end

  // N+1-bit arithmetic keeps MOD == 2^N wrapping correct
  always_comb begin
    cw     = {1'b0, cnt_q};
    nxt    = cw;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    req_d  = 1'b0;
    if (load) begin
      req_d = 1'b1;
      cnt_d = ({1'b0, load_val} < MOD_W) ? load_val : MODM1[N-1:0];
    end else if (tick && enable) begin
      req_d = 1'b1;
      if (up_dn) begin
        if (cw == MODM1) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          nxt   = cw + NW'(1);
          cnt_d = nxt[N-1:0];
        end
      end else begin
        if (cw == '0) begin
          cnt_d  = MODM1[N-1:0];
          wrap_d = 1'b1;
        end else begin
          nxt   = cw - NW'(1);
          cnt_d = nxt[N-1:0];
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      req_q  <= req_d;
    end
  end

  always_comb begin
    hex_d = '1;
    dig   = '0;
`ifdef LEADING_ZERO_BLANK_EN
    nz    = 1'b0;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dig = sh_q[N+4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (dig != 4'd0) nz = 1'b1;
      if (nz || k == 0) hex_d[7*k +: 7] = seg(dig);
`else
      hex_d[7*k +: 7] = seg(dig);
`endif
    end
  end

  // SHIFT spends one extra cycle on i==N before DONE
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      i_q       <= '0;
      sh_q      <= '0;
      hex_q     <= HEX_RST;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_q || pending_q) begin
            sh_q      <= {{BW{1'b0}}, cnt_q};
            pending_q <= 1'b0;
            i_q       <= '0;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (req_q) pending_q <= 1'b1;
          if (i_q == IW'(N)) begin
            state_q <= S_DONE;
          end else begin
            sh_q <= dd_step(sh_q);
            i_q  <= i_q + IW'(1);
          end
        end
        S_DONE: begin
          hex_q <= hex_d;
          if (pending_q || req_q) begin
            sh_q      <= {{BW{1'b0}}, cnt_q};
            pending_q <= 1'b0;
            i_q       <= '0;
            state_q   <= S_SHIFT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign count = cnt_q;
  assign wrap  = wrap_q;
  assign busy  = (state_q != S_IDLE);
  assign hex   = hex_q;

endmodule

// File: tb/tb_counter_bcd_hex.sv
// tb_counter_bcd_hex: directed checks of counting, clamp, BCD display timing.
// Honours LEADING_ZERO_BLANK_EN when computing expected displays.
module tb_counter_bcd_hex;
  localparam int N        = 8;
  localparam int MOD      = 200;
  localparam int DIGITS   = 3;
  localparam int PRESCALE = 11;
  localparam int LAT      = N + 3;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [20:0] HEX_RST = {14'h3FFF, 7'b1000000};
`else
  localparam logic [20:0] HEX_RST = {3{7'b1000000}};
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         ud = 1'b1;
  logic         ld = 1'b0;
  logic [N-1:0] lv = '0;
  logic [N-1:0] cnt;
  logic         wrp;
  logic         bsy;
  logic [20:0]  hx;

  int          checks = 0;
  int          errors = 0;
  bit          flag;
  bit          wsaw;
  logic [20:0] hmid;

  counter_bcd_hex #(
    .N(N), .MOD(MOD), .DIGITS(DIGITS), .PRESCALE(PRESCALE)
  ) dut (
    .CLOCK_50(clk),
    .reset_n (rst_n),
    .enable  (en),
    .up_dn   (ud),
    .load    (ld),
    .load_val(lv),
    .count   (cnt),
    .wrap    (wrp),
    .busy    (bsy),
    .hex     (hx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [20:0] disp(input int v);
    logic [20:0] h;
    int d0, d1, d2;
    d0 = v % 10;
    d1 = (v / 10) % 10;
    d2 = v / 100;
    h = {seg(d2), seg(d1), seg(d0)};
`ifdef LEADING_ZERO_BLANK_EN
    if (d2 == 0) begin
      h[20:14] = '1;
      if (d1 == 0) h[13:7] = '1;
    end
`endif
    return h;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_v(input logic [N-1:0] v);
    ld = 1'b1;
    lv = v;
    cyc(1);
    ld = 1'b0;
  endtask

  task automatic wait_cnt(input logic [N-1:0] old, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2 * PRESCALE && !seen; k++) begin
      @(negedge clk);
      if (cnt != old) seen = 1'b1;
    end
    chk(tag, 32'(seen), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    cyc(3);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_wrap", 32'(wrp), 0);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_hex", 32'(hx), 32'(HEX_RST));
    rst_n = 1'b1;
    en    = 1'b0;

    ud = 1'b1;
    load_v(8'd198);
    chk("up_load", 32'(cnt), 198);
    cyc(LAT + 2);
    en = 1'b1;
    wait_cnt(8'd198, "up_tick1");
    chk("up_199", 32'(cnt), 199);
    chk("up_nowrap", 32'(wrp), 0);
    wait_cnt(8'd199, "up_tick2");
    en = 1'b0;
    chk("up_wrap_val", 32'(cnt), 0);
    chk("up_wrap_hi", 32'(wrp), 1);
    cyc(1);
    chk("up_wrap_pulse", 32'(wrp), 0);
    cyc(LAT - 2);
    chk("up_hex_early", 32'(hx), 32'(disp(199)));
    chk("up_busy", 32'(bsy), 1);
    cyc(1);
    chk("up_hex", 32'(hx), 32'(disp(0)));
    chk("up_idle", 32'(bsy), 0);

    ud = 1'b0;
    load_v(8'd0);
    cyc(LAT + 2);
    chk("dn_load", 32'(cnt), 0);
    en = 1'b1;
    wait_cnt(8'd0, "dn_tick");
    en = 1'b0;
    chk("dn_val", 32'(cnt), 199);
    chk("dn_wrap", 32'(wrp), 1);
    cyc(LAT);
    chk("dn_hex", 32'(hx), 32'(disp(199)));

    load_v(8'd5);
    cyc(LAT + 2);
    chk("ld_5", 32'(cnt), 5);
    ud   = 1'b1;
    en   = 1'b1;
    ld   = 1'b1;
    lv   = 8'd250;
    wsaw = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 2 * PRESCALE; k++) begin
      @(negedge clk);
      if (wrp) wsaw = 1'b1;
      if (cnt != 8'd199) flag = 1'b1;
    end
    chk("clamp_cnt", 32'(cnt), 199);
    chk("clamp_nowrap", 32'(wsaw), 0);
    chk("clamp_hold", 32'(flag), 0);
    lv = 8'd57;
    cyc(1);
    ld = 1'b0;
    en = 1'b0;
    cyc(3 * LAT);
    chk("ld57_cnt", 32'(cnt), 57);
    chk("ld57_hex", 32'(hx), 32'(disp(57)));
    chk("ld57_idle", 32'(bsy), 0);

    ld = 1'b1;
    lv = 8'd10;
    cyc(1);
    lv = 8'd123;
    cyc(1);
    ld = 1'b0;
    chk("b2b_busy_start", 32'(bsy), 1);
    flag = 1'b0;
    hmid = '0;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (!bsy) flag = 1'b1;
      if (k == 11) hmid = hx;
    end
    chk("b2b_busy_cont", 32'(flag), 0);
    chk("b2b_first", 32'(hmid), 32'(disp(10)));
    cyc(1);
    chk("b2b_hex", 32'(hx), 32'(disp(123)));
    chk("b2b_done", 32'(bsy), 0);

    load_v(8'd77);
    cyc(3);
    chk("mid_busy", 32'(bsy), 1);
    rst_n = 1'b0;
    cyc(1);
    chk("mr_busy", 32'(bsy), 0);
    chk("mr_cnt", 32'(cnt), 0);
    chk("mr_hex", 32'(hx), 32'(HEX_RST));
    rst_n = 1'b1;
    flag  = 1'b0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (hx !== HEX_RST || bsy) flag = 1'b1;
    end
    chk("mr_stale", 32'(flag), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
